// File: rtl/bsg_pkg.sv
// bsg_pkg: shared definitions for the BSG transmit scheduler.
//   bsg_state_e      - scheduler FSM state encoding
//   CTRL_OFF         - control word that turns the transmitter off
//   CTRL_TXEN_INTMSK - control word TXENABLE|INTMSK (also clears INTFLAG)
//   DEF_ADDR_*       - default BSG register addresses
package bsg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_WR_DATA,
      ST_WR_CTRL,
      ST_WAIT_INT,
      ST_CLR_INT,
      ST_STOP
   } bsg_state_e;

   localparam logic [7:0] CTRL_OFF         = 8'h00;
   localparam logic [7:0] CTRL_TXEN_INTMSK = 8'h03;

   localparam logic [7:0] DEF_ADDR_CTRL = 8'h00;
   localparam logic [7:0] DEF_ADDR_D0   = 8'h01;
   localparam logic [7:0] DEF_ADDR_D1   = 8'h02;

   // Data register address for the given double-buffer slot.
   function automatic logic [7:0] data_addr(input logic slot, input logic [7:0] a0,
                                            input logic [7:0] a1);
      return slot ? a1 : a0;
   endfunction

endpackage

// File: rtl/bsg_rr_arbiter.sv
// bsg_rr_arbiter: two-requester arbiter feeding the BSG scheduler.
//   clk_sys  in  clock
//   rst_b    in  synchronous active-low reset
//   req      in  [1:0] request vector
//   accept   in  grant is taken this cycle (pointer advances)
//   grant    out [1:0] one-hot grant, combinational from req
// Build option: BSG_SCHED_PRIO_EN selects fixed priority (requester 0 wins);
// default is round-robin with the pointer starting at requester 0.
module bsg_rr_arbiter (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

`ifdef BSG_SCHED_PRIO_EN
   logic unused_prio;
   assign unused_prio = ^{clk_sys, rst_b, accept};

   always_comb begin
      grant = 2'b00;
      if (req[0]) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
   end
`else
   // ptr_q names the requester that wins when both are requesting.
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After serving requester 0 prefer 1, and vice versa.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && (|grant)) begin
         ptr_d = grant[0];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

endmodule

// File: rtl/bsg_tx_scheduler.sv
// bsg_tx_scheduler: feeds bytes from two requesters into a double-buffered
// BSG transmitter over a simple register write bus, priming both data
// registers, enabling the transmitter, then refilling one slot per interrupt.
// Ports:
//   SYS_CLK, RST_N          clock, synchronous active-low reset
//   en                      scheduler enable
//   req_valid/req_data0/1   requester byte offers; req_ready pulses on accept
//   bus_wr/addr/Data_in     register write strobe, address, data (to BSG)
//   ready                   bus ready; a write completes on bus_wr & ready
//   BSG_INT                 BSG interrupt, only looked at in WAIT_INT
//   busy/tx_active          not idle / transmitter enabled
//   err_timeout             sticky bus-ready timeout flag
//   tx_count                data bytes delivered (wraps)
// Build option: BSG_SCHED_PRIO_EN gives requester 0 fixed priority.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | disabled or nothing to send, strobes low
// ARB      | pick a requester and capture its byte (stays here on underrun)
// WR_DATA  | write captured byte to D0/D1 selected by slot
// WR_CTRL  | write TXENABLE|INTMSK after both slots are primed
// WAIT_INT | transmitter running, wait for interrupt or disable
// CLR_INT  | rewrite control word to clear INTFLAG, then refill a slot
// STOP     | write control word 0, then return to IDLE
module bsg_tx_scheduler
   import bsg_pkg::*;
#(
   parameter logic [7:0] ADDR_CTRL = DEF_ADDR_CTRL,
   parameter logic [7:0] ADDR_D0   = DEF_ADDR_D0,
   parameter logic [7:0] ADDR_D1   = DEF_ADDR_D1,
   parameter int         WAIT_MAX  = 255
) (
   input  logic        SYS_CLK,
   input  logic        RST_N,
   input  logic        en,
   input  logic [1:0]  req_valid,
   input  logic [7:0]  req_data0,
   input  logic [7:0]  req_data1,
   output logic [1:0]  req_ready,
   output logic        bus_wr,
   output logic [7:0]  addr,
   output logic [7:0]  Data_in,
   input  logic        ready,
   input  logic        BSG_INT,
   output logic        busy,
   output logic        tx_active,
   output logic        err_timeout,
   output logic [15:0] tx_count
);

   localparam int              WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(WAIT_MAX - 1);

   bsg_state_e     state_q, state_d;
   logic           slot_q, slot_d;
   logic           tx_active_q, tx_active_d;
   logic           err_q, err_d;
   logic [15:0]    tx_count_q, tx_count_d;
   logic           bus_wr_q, bus_wr_d;
   logic [7:0]     addr_q, addr_d;
   logic [7:0]     data_in_q, data_in_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

   logic [1:0]     grant;
   logic           arb_go;
   logic           wr_done;
   logic           wr_tmo;
   logic           start_wr;

   bsg_rr_arbiter u_arb (
      .clk_sys (SYS_CLK),
      .rst_b   (RST_N),
      .req     (req_valid),
      .accept  (arb_go),
      .grant   (grant)
   );

   // en is only honoured in ARB before granting, so no byte is taken on disable.
   assign arb_go    = (state_q == ST_ARB) && en && (|grant);
   assign wr_done   = bus_wr_q && ready;
   assign wr_tmo    = bus_wr_q && !ready && (wait_cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      tx_active_d = tx_active_q;
      err_d       = err_q;
      tx_count_d  = tx_count_q;
      bus_wr_d    = bus_wr_q;
      addr_d      = addr_q;
      data_in_d   = data_in_q;
      wait_cnt_d  = wait_cnt_q;
      start_wr    = 1'b0;

      if (bus_wr_q && !ready && (wait_cnt_q != '0)) begin
         wait_cnt_d = wait_cnt_q - WCW'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (en && (|req_valid)) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (!en) begin
               if (tx_active_q) begin
                  state_d   = ST_STOP;
                  bus_wr_d  = 1'b1;
                  addr_d    = ADDR_CTRL;
                  data_in_d = CTRL_OFF;
                  start_wr  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (|grant) begin
               state_d   = ST_WR_DATA;
               bus_wr_d  = 1'b1;
               addr_d    = data_addr(slot_q, ADDR_D0, ADDR_D1);
               data_in_d = grant[1] ? req_data1 : req_data0;
               start_wr  = 1'b1;
            end
         end
         ST_WR_DATA: begin
            if (wr_done) begin
               slot_d     = ~slot_q;
               tx_count_d = tx_count_q + 16'd1;
               if (tx_active_q) begin
                  // Only a post-interrupt refill reaches here while active.
                  state_d  = ST_WAIT_INT;
                  bus_wr_d = 1'b0;
               end else if (slot_q) begin
                  state_d   = ST_WR_CTRL;
                  addr_d    = ADDR_CTRL;
                  data_in_d = CTRL_TXEN_INTMSK;
                  start_wr  = 1'b1;
               end else begin
                  state_d  = ST_ARB;
                  bus_wr_d = 1'b0;
               end
            end
         end
         ST_WR_CTRL: begin
            if (wr_done) begin
               tx_active_d = 1'b1;
               state_d     = ST_WAIT_INT;
               bus_wr_d    = 1'b0;
            end
         end
         ST_WAIT_INT: begin
            if (BSG_INT) begin
               state_d   = ST_CLR_INT;
               bus_wr_d  = 1'b1;
               addr_d    = ADDR_CTRL;
               data_in_d = CTRL_TXEN_INTMSK;
               start_wr  = 1'b1;
            end else if (!en) begin
               state_d   = ST_STOP;
               bus_wr_d  = 1'b1;
               addr_d    = ADDR_CTRL;
               data_in_d = CTRL_OFF;
               start_wr  = 1'b1;
            end
         end
         ST_CLR_INT: begin
            if (wr_done) begin
               state_d  = ST_ARB;
               bus_wr_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (wr_done) begin
               state_d     = ST_IDLE;
               bus_wr_d    = 1'b0;
               tx_active_d = 1'b0;
               slot_d      = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            bus_wr_d = 1'b0;
         end
      endcase

      // A stuck bus abandons whatever write was in progress.
      if (wr_tmo) begin
         state_d     = ST_IDLE;
         bus_wr_d    = 1'b0;
         err_d       = 1'b1;
         tx_active_d = 1'b0;
         slot_d      = 1'b0;
      end

      if (start_wr) begin
         wait_cnt_d = WAIT_LOAD;
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         slot_q      <= 1'b0;
         tx_active_q <= 1'b0;
         err_q       <= 1'b0;
         tx_count_q  <= 16'd0;
         bus_wr_q    <= 1'b0;
         addr_q      <= 8'h00;
         data_in_q   <= 8'h00;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         tx_active_q <= tx_active_d;
         err_q       <= err_d;
         tx_count_q  <= tx_count_d;
         bus_wr_q    <= bus_wr_d;
         addr_q      <= addr_d;
         data_in_q   <= data_in_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   // req_ready is the accept half of a same-cycle valid/ready handshake.
   assign req_ready   = arb_go ? grant : 2'b00;
   assign bus_wr      = bus_wr_q;
   assign addr        = addr_q;
   assign Data_in     = data_in_q;
   assign busy        = (state_q != ST_IDLE);
   assign tx_active   = tx_active_q;
   assign err_timeout = err_q;
   assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_bsg_tx_scheduler.sv
module tb_bsg_tx_scheduler;

   localparam int WAIT_MAX = 255;

   logic        SYS_CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [7:0]  req_data0 = 8'h00;
   logic [7:0]  req_data1 = 8'h00;
   logic [1:0]  req_ready;
   logic        bus_wr;
   logic [7:0]  addr;
   logic [7:0]  Data_in;
   logic        ready = 1'b1;
   logic        BSG_INT = 1'b0;
   logic        busy;
   logic        tx_active;
   logic        err_timeout;
   logic [15:0] tx_count;

   bsg_tx_scheduler #(
      .ADDR_CTRL (8'h00),
      .ADDR_D0   (8'h01),
      .ADDR_D1   (8'h02),
      .WAIT_MAX  (WAIT_MAX)
   ) dut (
      .SYS_CLK     (SYS_CLK),
      .RST_N       (RST_N),
      .en          (en),
      .req_valid   (req_valid),
      .req_data0   (req_data0),
      .req_data1   (req_data1),
      .req_ready   (req_ready),
      .bus_wr      (bus_wr),
      .addr        (addr),
      .Data_in     (Data_in),
      .ready       (ready),
      .BSG_INT     (BSG_INT),
      .busy        (busy),
      .tx_active   (tx_active),
      .err_timeout (err_timeout),
      .tx_count    (tx_count)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   int          total = 0;
   int          bad = 0;
   logic [15:0] wr_log[$];
   int          grant_log[$];
   logic [7:0]  src0[$];
   logic [7:0]  src1[$];
   logic [1:0]  src_on = 2'b00;
   bit          rand_ready = 1'b0;
   int          exp_slot = 0;
   int          exp_cnt = 0;

   // One clock: present requester heads, log handshakes that complete at
   // the coming edge, then advance to the next falling edge.
   task automatic tick();
      req_valid[0] = src_on[0] && (src0.size() > 0);
      req_valid[1] = src_on[1] && (src1.size() > 0);
      req_data0 = (src0.size() > 0) ? src0[0] : 8'h00;
      req_data1 = (src1.size() > 0) ? src1[0] : 8'h00;
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus_wr === 1'b1 && ready === 1'b1) wr_log.push_back({addr, Data_in});
      if (req_ready[0] === 1'b1) begin grant_log.push_back(0); src0.delete(0); end
      if (req_ready[1] === 1'b1) begin grant_log.push_back(1); src1.delete(0); end
      @(posedge SYS_CLK);
      @(negedge SYS_CLK);
   endtask

   task automatic wait_writes(input int n, input int budget, output bit ok);
      int c = 0;
      while (wr_log.size() < n && c < budget) begin
         tick();
         c++;
      end
      ok = (wr_log.size() >= n);
   endtask

   task automatic do_reset();
      RST_N = 1'b0; en = 1'b0; ready = 1'b1; BSG_INT = 1'b0; rand_ready = 1'b0;
      src_on = 2'b00; src0.delete(); src1.delete();
      tick(); tick();
      RST_N = 1'b1;
      wr_log.delete(); grant_log.delete();
      exp_slot = 0; exp_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      src0.push_back(8'h11); src_on = 2'b01;
      tick();
      total++; if (bus_wr !== 1'b0) begin bad++; $display("FAIL reset_bus_wr: got=%b want=0", bus_wr); end
      total++; if (addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got=%h want=00", addr); end
      total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL reset_data: got=%h want=00", Data_in); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got=%b want=00", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
      total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL reset_tx_active: got=%b want=0", tx_active); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got=%b want=0", err_timeout); end
      total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL reset_tx_count: got=%0d want=0", tx_count); end
   endtask

   // Requester 0 offers A5 then 3C; BSG_INT is high early on and must be ignored.
   task automatic test_prime();
      bit ok;
      logic [15:0] exp[3];
      exp[0] = 16'h01A5; exp[1] = 16'h023C; exp[2] = 16'h0003;
      do_reset();
      en = 1'b1; ready = 1'b1;
      src0.push_back(8'hA5); src0.push_back(8'h3C); src_on = 2'b01;
      BSG_INT = 1'b1;
      tick(); tick(); tick();
      BSG_INT = 1'b0;
      wait_writes(3, 40, ok);
      total++; if (!ok) begin bad++; $display("FAIL prime_wait: writes=%0d want=3", wr_log.size()); end
      repeat (6) tick();
      total++;
      if (wr_log.size() != 3) begin
         bad++; $display("FAIL prime_count: writes=%0d want=3", wr_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (wr_log[i] !== exp[i]) begin
               bad++; $display("FAIL prime_write%0d: got=%h want=%h", i, wr_log[i], exp[i]);
            end
         end
      end
      total++; if (tx_active !== 1'b1) begin bad++; $display("FAIL prime_tx_active: got=%b want=1", tx_active); end
      total++; if (tx_count !== 16'd2) begin bad++; $display("FAIL prime_tx_count: got=%0d want=2", tx_count); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL prime_busy: got=%b want=1", busy); end
      exp_slot = 0; exp_cnt = 2;
   endtask

   // Random refills from a random requester with random ready stalls.
   task automatic test_refill();
      bit ok;
      int r, base, gbase;
      logic [7:0] nb;
      src_on = 2'b11;
      rand_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         r = $urandom_range(0, 1);
         nb = 8'($urandom_range(0, 255));
         if (r == 1) src1.push_back(nb); else src0.push_back(nb);
         base = wr_log.size(); gbase = grant_log.size();
         BSG_INT = 1'b1; tick(); BSG_INT = 1'b0;
         wait_writes(base + 2, 80, ok);
         total++; if (!ok) begin bad++; $display("FAIL refill%0d_wait: writes=%0d want=%0d", k, wr_log.size(), base + 2); end
         if (ok) begin
            total++;
            if (wr_log[base] !== 16'h0003) begin
               bad++; $display("FAIL refill%0d_ctrl: got=%h want=0003", k, wr_log[base]);
            end
            total++;
            if (wr_log[base + 1] !== {(exp_slot == 1) ? 8'h02 : 8'h01, nb}) begin
               bad++; $display("FAIL refill%0d_data: got=%h want=%h", k, wr_log[base + 1],
                               {(exp_slot == 1) ? 8'h02 : 8'h01, nb});
            end
         end
         total++;
         if (grant_log.size() != gbase + 1 || grant_log[gbase] != r) begin
            bad++; $display("FAIL refill%0d_grant: grants=%0d want_req=%0d", k, grant_log.size() - gbase, r);
         end
         exp_slot ^= 1; exp_cnt++;
         tick();
         total++;
         if (tx_count !== 16'(exp_cnt)) begin
            bad++; $display("FAIL refill%0d_tx_count: got=%0d want=%0d", k, tx_count, exp_cnt);
         end
      end
      rand_ready = 1'b0; ready = 1'b1;
      base = wr_log.size();
      repeat (20) tick();
      total++; if (wr_log.size() != base) begin bad++; $display("FAIL refill_quiet: writes=%0d want=%0d", wr_log.size(), base); end
   endtask

   // Interrupt with nothing queued: control write, then sit in ARB until a byte arrives.
   task automatic test_underrun();
      bit ok;
      int base;
      logic [7:0] nb;
      base = wr_log.size();
      BSG_INT = 1'b1; tick(); BSG_INT = 1'b0;
      wait_writes(base + 1, 40, ok);
      total++; if (!ok || wr_log[base] !== 16'h0003) begin bad++; $display("FAIL underrun_ctrl: writes=%0d want=%0d", wr_log.size(), base + 1); end
      repeat (20) tick();
      total++; if (wr_log.size() != base + 1) begin bad++; $display("FAIL underrun_hold: writes=%0d want=%0d", wr_log.size(), base + 1); end
      total++; if (busy !== 1'b1 || tx_active !== 1'b1) begin bad++; $display("FAIL underrun_state: busy=%b tx_active=%b want=1,1", busy, tx_active); end
      nb = 8'($urandom_range(0, 255));
      src0.push_back(nb);
      wait_writes(base + 2, 40, ok);
      total++;
      if (!ok || wr_log[base + 1] !== {(exp_slot == 1) ? 8'h02 : 8'h01, nb}) begin
         bad++; $display("FAIL underrun_data: writes=%0d want=%0d", wr_log.size(), base + 2);
      end
      exp_slot ^= 1; exp_cnt++;
      tick();
      total++; if (tx_count !== 16'(exp_cnt)) begin bad++; $display("FAIL underrun_tx_count: got=%0d want=%0d", tx_count, exp_cnt); end
   endtask

   task automatic test_stop();
      bit ok;
      int base;
      base = wr_log.size();
      en = 1'b0;
      wait_writes(base + 1, 20, ok);
      total++; if (!ok || wr_log[base] !== 16'h0000) begin bad++; $display("FAIL stop_write: writes=%0d want=%0d", wr_log.size(), base + 1); end
      repeat (5) tick();
      total++; if (wr_log.size() != base + 1) begin bad++; $display("FAIL stop_single: writes=%0d want=%0d", wr_log.size(), base + 1); end
      total++; if (tx_active !== 1'b0) begin bad++; $display("FAIL stop_tx_active: got=%b want=0", tx_active); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got=%b want=0", busy); end
   endtask

   task automatic test_wait_states();
      bit seen = 1'b0;
      logic [7:0] a, d;
      do_reset();
      en = 1'b1; ready = 1'b0;
      src0.push_back(8'h5A); src_on = 2'b01;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         seen = (bus_wr === 1'b1);
      end
      total++; if (!seen) begin bad++; $display("FAIL ws_start: bus_wr=%b want=1", bus_wr); end
      a = addr; d = Data_in;
      total++; if (a !== 8'h01 || d !== 8'h5A) begin bad++; $display("FAIL ws_first: got=%h%h want=015A", a, d); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus_wr !== 1'b1 || addr !== a || Data_in !== d) begin
            bad++; $display("FAIL ws_stable%0d: got=%b/%h/%h want=1/%h/%h", i, bus_wr, addr, Data_in, a, d);
         end
      end
      total++; if (wr_log.size() != 0) begin bad++; $display("FAIL ws_early: writes=%0d want=0", wr_log.size()); end
      ready = 1'b1;
      tick();
      total++; if (wr_log.size() != 1 || wr_log[0] !== 16'h015A) begin bad++; $display("FAIL ws_done: writes=%0d want=1", wr_log.size()); end
      tick();
      total++; if (bus_wr !== 1'b0 || tx_count !== 16'd1) begin bad++; $display("FAIL ws_after: bus_wr=%b tx_count=%0d want=0,1", bus_wr, tx_count); end
   endtask

   task automatic test_reset_midwrite();
      bit seen = 1'b0;
      src0.push_back(8'hC3);
      ready = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         seen = (bus_wr === 1'b1);
      end
      total++; if (!seen || addr !== 8'h02) begin bad++; $display("FAIL mid_start: bus_wr=%b addr=%h want=1,02", bus_wr, addr); end
      RST_N = 1'b0;
      tick();
      total++;
      if (bus_wr !== 1'b0 || addr !== 8'h00 || Data_in !== 8'h00 || busy !== 1'b0 ||
          tx_count !== 16'd0 || tx_active !== 1'b0 || err_timeout !== 1'b0 || req_ready !== 2'b00) begin
         bad++; $display("FAIL mid_reset: bus_wr=%b addr=%h data=%h busy=%b cnt=%0d want all zero",
                         bus_wr, addr, Data_in, busy, tx_count);
      end
      RST_N = 1'b1;
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL mid_nocomplete: writes=%0d want=1", wr_log.size()); end
   endtask

   // Both requesters always valid: expected grant order comes from the policy alone.
   task automatic test_arbitration();
      bit ok;
      int base;
      logic [7:0] o0[8], o1[8];
      logic [15:0] dq[$];
      int er;
      logic [7:0] eb;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         o0[i] = 8'($urandom_range(0, 255)); o1[i] = 8'($urandom_range(0, 255));
         src0.push_back(o0[i]); src1.push_back(o1[i]);
      end
      src_on = 2'b11; en = 1'b1; rand_ready = 1'b1;
      wait_writes(3, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL arb_prime: writes=%0d want=3", wr_log.size()); end
      for (int k = 0; k < 4; k++) begin
         base = wr_log.size();
         BSG_INT = 1'b1; tick(); BSG_INT = 1'b0;
         wait_writes(base + 2, 100, ok);
      end
      rand_ready = 1'b0; ready = 1'b1;
      foreach (wr_log[i]) if (wr_log[i][15:8] != 8'h00) dq.push_back(wr_log[i]);
      total++;
      if (grant_log.size() != 6 || dq.size() != 6) begin
         bad++; $display("FAIL arb_count: grants=%0d data=%0d want=6,6", grant_log.size(), dq.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
`ifdef BSG_SCHED_PRIO_EN
            er = 0; eb = o0[j];
`else
            er = j % 2; eb = (er == 1) ? o1[j / 2] : o0[j / 2];
`endif
            total++;
            if (grant_log[j] != er || dq[j] !== {(j % 2 == 1) ? 8'h02 : 8'h01, eb}) begin
               bad++; $display("FAIL arb_grant%0d: got=req%0d/%h want=req%0d/%h", j, grant_log[j], dq[j], er,
                               {(j % 2 == 1) ? 8'h02 : 8'h01, eb});
            end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int hi = 0;
      do_reset();
      en = 1'b1; ready = 1'b0;
      src0.push_back(8'($urandom_range(0, 255))); src_on = 2'b01;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (bus_wr === 1'b1) hi++;
         else if (hi > 0) break;
      end
      total++; if (hi != WAIT_MAX) begin bad++; $display("FAIL tmo_cycles: got=%0d want=%0d", hi, WAIT_MAX); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_err: got=%b want=1", err_timeout); end
      total++; if (busy !== 1'b0 || tx_active !== 1'b0) begin bad++; $display("FAIL tmo_idle: busy=%b tx_active=%b want=0,0", busy, tx_active); end
      total++; if (wr_log.size() != 0) begin bad++; $display("FAIL tmo_nowrite: writes=%0d want=0", wr_log.size()); end
      ready = 1'b1;
      src0.push_back(8'h77); src0.push_back(8'h88);
      wait_writes(3, 40, ok);
      total++; if (!ok || wr_log[0] !== 16'h0177) begin bad++; $display("FAIL tmo_reprime: writes=%0d want=3", wr_log.size()); end
      tick();
      total++; if (err_timeout !== 1'b1 || tx_active !== 1'b1) begin bad++; $display("FAIL tmo_sticky: err=%b tx_active=%b want=1,1", err_timeout, tx_active); end
      do_reset();
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got=%b want=0", err_timeout); end
   endtask

   initial begin
      @(negedge SYS_CLK);
      test_reset();
      test_prime();
      test_refill();
      test_underrun();
      test_stop();
      test_wait_states();
      test_reset_midwrite();
      test_arbitration();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bsg_tx_scheduler.md
BSG_TX_SCHEDULER -- requirements
Module: bsg_tx_scheduler

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 8'h00: BSG control register address.
REQ-002 SHALL have parameter ADDR_D0, default 8'h01: BSG data register 0 address.
REQ-003 SHALL have parameter ADDR_D1, default 8'h02: BSG data register 1 address.
REQ-004 SHALL have parameter WAIT_MAX, default 255: bus-ready timeout in cycles.
REQ-005 SHALL have ports: SYS_CLK in 1, system clock; RST_N in 1, reset, synchronous active-low.
REQ-006 SHALL have ports: en in 1, scheduler enable; req_valid in 2, per-requester byte valid; req_data0 and req_data1 in 8 each, requester bytes; req_ready out 2, one-cycle byte accept.
REQ-007 SHALL have ports: bus_wr out 1, write strobe; addr out 8, register address; Data_in out 8, write data to BSG; ready in 1, BSG bus ready; BSG_INT in 1, BSG interrupt.
REQ-008 SHALL have ports: busy out 1, not IDLE; tx_active out 1, TXENABLE written high; err_timeout out 1, sticky timeout flag; tx_count out 16, bytes delivered.

Function
REQ-009 SHALL implement states IDLE, ARB, WR_DATA, WR_CTRL, WAIT_INT, CLR_INT, STOP.
REQ-010 IDLE: en=1 and any req_valid -> ARB; otherwise hold with all strobes low.
REQ-011 ARB (1 cycle): grant one requester, pulse its req_ready bit, capture its byte, -> WR_DATA; no valid request -> remain in ARB.
REQ-012 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; first grant after reset goes to requester 0.
REQ-013 WR_DATA: bus_wr=1, addr=slot?ADDR_D1:ADDR_D0, Data_in=captured byte, all held stable until ready=1; a write completes on the cycle bus_wr=1 and ready=1.
REQ-014 Data write completion SHALL toggle slot and increment tx_count; tx_count wraps 16'hFFFF -> 0.
REQ-015 Before tx_active: after the slot-1 write -> WR_CTRL; after the slot-0 write -> ARB.
REQ-016 WR_CTRL: write 8'h03 (TXENABLE|INTMSK) to ADDR_CTRL; on completion tx_active=1 -> WAIT_INT.
REQ-017 WAIT_INT: BSG_INT=1 -> CLR_INT; en=0 -> STOP.
REQ-018 CLR_INT: write 8'h03 to ADDR_CTRL (INTFLAG cleared); on completion -> ARB to refill the current slot; after this refill, data-write completion -> WAIT_INT.
REQ-019 While tx_active and in ARB with no request (underrun): remain in ARB; BSG retransmits stale data; no flag.
REQ-020 en=0 SHALL be sampled only in IDLE, ARB, WAIT_INT; an in-flight bus write always completes first.
REQ-021 STOP: write 8'h00 to ADDR_CTRL; on completion clear tx_active, slot=0 -> IDLE.
REQ-022 Any bus write with ready low for WAIT_MAX consecutive cycles SHALL abort: bus_wr=0, err_timeout=1 (sticky until reset), tx_active=0, slot=0, -> IDLE.
REQ-023 BSG_INT asserted outside WAIT_INT SHALL be ignored; the level is re-sampled in WAIT_INT.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 RST_N=0 at a rising SYS_CLK edge SHALL force IDLE, bus_wr=0, addr=0, Data_in=0, req_ready=0, tx_active=0, err_timeout=0, tx_count=0, slot=0, round-robin pointer to requester 0.
REQ-026 Reset mid-write SHALL drop bus_wr on the next cycle without completing the write.

Configuration
REQ-027 With BSG_SCHED_PRIO_EN defined, requester 0 SHALL have fixed priority over requester 1; without it, round-robin per REQ-012.

Structure
REQ-028 Package bsg_pkg SHALL hold the state enum, control-word constants (8'h00, 8'h03) and default register addresses.
REQ-029 Arbitration SHALL live in sub-module bsg_rr_arbiter (2 requesters, grant-on-request, pointer update on accept).

Verification
REQ-030 Prime: req_valid=2'b01 with bytes 8'hA5, 8'h3C, ready=1 -> writes D0=A5, D1=3C, CTRL=03; tx_active=1; tx_count=2.
REQ-031 Refill: after prime, pulse BSG_INT -> CTRL=03 write, then D0 write with next byte; tx_count=3.
REQ-032 Arbitration: both requesters valid continuously -> grants alternate 0,1,0,1; with BSG_SCHED_PRIO_EN -> all grants to 0.
REQ-033 Timeout: ready held 0 for 255 cycles during a D0 write -> bus_wr drops, err_timeout=1, IDLE.
REQ-034 Stop: en=0 in WAIT_INT -> single CTRL=00 write; tx_active=0; IDLE.
REQ-035 Wait states and reset: ready low 3 cycles -> addr/Data_in stable, one completion; RST_N=0 mid-write -> all outputs at reset values next cycle.
